// File: rtl/tone_param_calc_pkg.sv
// Shared types and default constants for the tone parameter calculator.
// Optional amplitude averaging is enabled with TONE_AVG_EN.
package tone_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOT,
        MUL,
        SAT,
        OUT,
        AVG
    } state_t;

    localparam logic [31:0] FREQ_K_DEF    = 32'd2684354;
    localparam logic [15:0] AMP_GAIN_DEF  = 16'h4000;
    localparam int          AMP_SHIFT_DEF = 14;
    localparam int          AMP_WORD_W    = 16;

endpackage

// File: rtl/tone_param_calc_if.sv
// Peak/root capture inputs and DDS config / amplitude outputs.
// master drives peak/root strobes, slave is the calculator.
interface tone_param_calc_if
    import tone_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int ROOT_WIDTH = 25,
    parameter int PINC_WIDTH = 32
);
    logic                  peak_valid;
    logic [ADDR_WIDTH-1:0] peak_addr;
    logic                  root_valid;
    logic [ROOT_WIDTH-1:0] root_data;
    logic                  cfg_tvalid;
    logic [PINC_WIDTH-1:0] cfg_tdata;
    logic [AMP_WORD_W-1:0] amp_word;
    logic                  busy;
    logic                  err_timeout;

    modport master (
        output peak_valid, peak_addr, root_valid, root_data,
        input  cfg_tvalid, cfg_tdata, amp_word, busy, err_timeout
    );

    modport slave (
        input  peak_valid, peak_addr, root_valid, root_data,
        output cfg_tvalid, cfg_tdata, amp_word, busy, err_timeout
    );
endinterface

// File: rtl/tone_param_calc_sat_trunc.sv
// Unsigned right shift followed by saturation to OUT_W bits.
module sat_trunc #(
    parameter int IN_W  = 40,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);
    logic [IN_W-1:0] sh;

    assign sh = din >> SHIFT;

    generate
        if (IN_W > OUT_W) begin : g_sat
            assign dout = (|sh[IN_W-1:OUT_W]) ? '1 : sh[OUT_W-1:0];
        end else begin : g_pass
            assign dout = OUT_W'(sh);
        end
    endgenerate
endmodule

// File: rtl/tone_param_calc.sv
// Peak bin + root amplitude -> DDS phase increment and amplitude word.
// Define TONE_AVG_EN to average the last 4 amplitude words.
module tone_param_calc
    import tone_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          ROOT_WIDTH = 25,
    parameter int          PINC_WIDTH = 32,
    parameter logic [31:0] FREQ_K     = FREQ_K_DEF,
    parameter logic [15:0] AMP_GAIN   = AMP_GAIN_DEF,
    parameter int          AMP_SHIFT  = AMP_SHIFT_DEF,
    parameter int          TIMEOUT    = 64
) (
    input logic               clk,
    input logic               rst,
    tone_param_calc_if.slave  io
);
    localparam int PW   = ADDR_WIDTH + 32;
    localparam int AW   = ROOT_WIDTH + 16;
    localparam int CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ROOT_WIDTH-1:0] root_q;
    logic [CW-1:0]         cnt;
    logic [PW-1:0]         pinc_full;
    logic [AW-1:0]         amp_full;
    logic [PINC_WIDTH-1:0] pinc_sat;
    logic [PINC_WIDTH-1:0] pinc_cand;
    logic [AMP_WORD_W-1:0] amp_sat;
    logic [AMP_WORD_W-1:0] amp_cand;
    logic                  cfg_tvalid;
    logic [PINC_WIDTH-1:0] cfg_tdata;
    logic [AMP_WORD_W-1:0] amp_word;
    logic                  err_timeout;
`ifdef TONE_AVG_EN
    logic [AMP_WORD_W-1:0] hist [4];
    logic [17:0]           acc;
    logic                  primed;
`endif

    sat_trunc #(.IN_W(PW), .OUT_W(PINC_WIDTH), .SHIFT(0)) u_pinc (
        .din  (pinc_full),
        .dout (pinc_sat)
    );

    sat_trunc #(.IN_W(AW), .OUT_W(AMP_WORD_W), .SHIFT(AMP_SHIFT)) u_amp (
        .din  (amp_full),
        .dout (amp_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            root_q      <= '0;
            cnt         <= '0;
            pinc_full   <= '0;
            amp_full    <= '0;
            pinc_cand   <= '0;
            amp_cand    <= '0;
            cfg_tvalid  <= 1'b0;
            cfg_tdata   <= '0;
            amp_word    <= '0;
            err_timeout <= 1'b0;
`ifdef TONE_AVG_EN
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            acc         <= '0;
            primed      <= 1'b0;
`endif
        end else begin
            cfg_tvalid  <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (io.peak_valid) begin
                        addr_q <= io.peak_addr;
                        cnt    <= '0;
                        state  <= WAIT_ROOT;
                    end
                end
                WAIT_ROOT: begin
                    // root wins over a simultaneous new peak
                    if (io.root_valid) begin
                        root_q <= io.root_data;
                        state  <= MUL;
                    end else if (io.peak_valid) begin
                        addr_q <= io.peak_addr;
                        cnt    <= '0;
                    end else if (cnt == CMAX) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MUL: begin
                    pinc_full <= PW'(addr_q) * PW'(FREQ_K);
                    amp_full  <= AW'(root_q) * AW'(AMP_GAIN);
                    state     <= SAT;
                end
                SAT: begin
                    pinc_cand <= (addr_q == '0) ? '0 : pinc_sat;
                    amp_cand  <= (addr_q == '0) ? '0 : amp_sat;
`ifdef TONE_AVG_EN
                    state     <= AVG;
`else
                    state     <= OUT;
`endif
                end
`ifdef TONE_AVG_EN
                AVG: begin
                    // first frame seeds the whole window
                    if (!primed) begin
                        for (int i = 0; i < 4; i++) hist[i] <= amp_cand;
                        acc    <= {amp_cand, 2'b00};
                        primed <= 1'b1;
                    end else begin
                        hist[0] <= amp_cand;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        hist[3] <= hist[2];
                        acc     <= acc - 18'(hist[3]) + 18'(amp_cand);
                    end
                    state <= OUT;
                end
`endif
                OUT: begin
                    cfg_tdata  <= pinc_cand;
`ifdef TONE_AVG_EN
                    amp_word   <= acc[17:2];
`else
                    amp_word   <= amp_cand;
`endif
                    cfg_tvalid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.cfg_tvalid  = cfg_tvalid;
    assign io.cfg_tdata   = cfg_tdata;
    assign io.amp_word    = amp_word;
    assign io.err_timeout = err_timeout;
    assign io.busy        = (state != IDLE);
endmodule

// File: tb/tb_tone_param_calc.sv
// Directed frames with a queue scoreboard and a negedge monitor.
module tb_tone_param_calc;
    import tone_pkg::*;

`ifdef TONE_AVG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [31:0] cfg;
        logic [15:0] amp;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q1[$];
    exp_t q2[$];
    int   eq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tone_param_calc_if #(.ADDR_WIDTH(8), .ROOT_WIDTH(25), .PINC_WIDTH(32)) bus ();
    tone_param_calc_if #(.ADDR_WIDTH(8), .ROOT_WIDTH(25), .PINC_WIDTH(32)) bus2 ();

    tone_param_calc dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    tone_param_calc #(.FREQ_K(32'hFFFF_FFFF)) dut2 (
        .clk (clk),
        .rst (rst),
        .io  (bus2)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.cfg_tvalid === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL beat_unexpected: got cfg_tvalid=1, expected 0 (cyc %0d)", cyc);
            end else begin
                e = q1.pop_front();
                chk("cfg_tdata", bus.cfg_tdata, e.cfg);
                chk("amp_word", 32'(bus.amp_word), 32'(e.amp));
                chk("latency", cyc, e.due);
            end
        end
        if (bus2.cfg_tvalid === 1'b1) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL beat2_unexpected: got cfg_tvalid=1, expected 0 (cyc %0d)", cyc);
            end else begin
                e = q2.pop_front();
                chk("cfg_tdata2", bus2.cfg_tdata, e.cfg);
                chk("amp_word2", 32'(bus2.amp_word), 32'(e.amp));
                chk("latency2", cyc, e.due);
            end
        end
        if (bus.err_timeout === 1'b1) begin
            if (eq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL err_unexpected: got err_timeout=1, expected 0 (cyc %0d)", cyc);
            end else begin
                chk("err_cycle", cyc, eq.pop_front());
            end
        end
        if (bus2.err_timeout === 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL err2_unexpected: got err_timeout=1, expected 0 (cyc %0d)", cyc);
        end
    end

    task automatic drive(bit d2, bit pv, logic [7:0] pa, bit rv, logic [24:0] rd);
        if (d2) begin
            bus2.peak_valid = pv;
            bus2.peak_addr  = pa;
            bus2.root_valid = rv;
            bus2.root_data  = rd;
        end else begin
            bus.peak_valid = pv;
            bus.peak_addr  = pa;
            bus.root_valid = rv;
            bus.root_data  = rd;
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(bit d2, logic [31:0] c, logic [15:0] a);
        exp_t e;
        e.cfg = c;
        e.amp = a;
        e.due = cyc + 1 + LAT;
        if (d2) q2.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic frame(bit d2, logic [7:0] a, logic [24:0] r,
                         logic [31:0] ec, logic [15:0] ea);
        @(negedge clk);
        drive(d2, 1'b1, a, 1'b0, '0);
        @(negedge clk);
        drive(d2, 1'b0, '0, 1'b1, r);
        push(d2, ec, ea);
        @(negedge clk);
        drive(d2, 1'b0, '0, 1'b0, '0);
        idle(LAT + 2);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        idle(3);
        chk("rst_cfg_tvalid", 32'(bus.cfg_tvalid), 0);
        chk("rst_cfg_tdata", bus.cfg_tdata, 0);
        chk("rst_amp_word", 32'(bus.amp_word), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err_timeout", 32'(bus.err_timeout), 0);
        rst = 1'b0;
        idle(2);

`ifdef TONE_AVG_EN
        frame(1'b0, 8'd1, 25'd400, 32'd2684354, 16'd400);
        frame(1'b0, 8'd1, 25'd800, 32'd2684354, 16'd500);
        frame(1'b0, 8'd1, 25'd800, 32'd2684354, 16'd600);
        frame(1'b0, 8'd1, 25'd800, 32'd2684354, 16'd700);
`else
        frame(1'b0, 8'd10, 25'd1000, 32'd26843540, 16'd1000);
        frame(1'b0, 8'd1, 25'h0FF_FFFF, 32'd2684354, 16'd65535);
        frame(1'b1, 8'd255, 25'd1000, 32'hFFFF_FFFF, 16'd1000);

        // timeout: no root after peak
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd7, 1'b0, '0);
        eq.push_back(cyc + 1 + 64);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        chk("busy_waiting", 32'(bus.busy), 1);
        idle(70);
        chk("busy_after_to", 32'(bus.busy), 0);
        chk("held_cfg_tdata", bus.cfg_tdata, 32'd2684354);
        chk("held_amp_word", 32'(bus.amp_word), 32'd65535);

        // root in IDLE is ignored
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 25'd77);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        idle(6);
        chk("busy_idle_root", 32'(bus.busy), 0);

        // peak relatch while waiting
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd5, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        idle(3);
        drive(1'b0, 1'b1, 8'd2, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 25'd100);
        push(1'b0, 32'd5368708, 16'd100);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        idle(LAT + 2);

        // simultaneous peak and root: root taken, old address kept
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd4, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd9, 1'b1, 25'd300);
        push(1'b0, 32'd10737416, 16'd300);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        idle(LAT + 2);

        frame(1'b0, 8'd0, 25'd5000, 32'd0, 16'd0);

        // reset the cycle after root
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd6, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 25'd50);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cfg_tdata", bus.cfg_tdata, 0);
        chk("abort_amp_word", 32'(bus.amp_word), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_cfg_tvalid", 32'(bus.cfg_tvalid), 0);
        idle(LAT + 2);

        frame(1'b0, 8'd3, 25'd200, 32'd8053062, 16'd200);

        // peak during MUL is dropped
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd8, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 25'd10);
        push(1'b0, 32'd21474832, 16'd10);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd11, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        idle(LAT + 2);
        chk("busy_after_drop", 32'(bus.busy), 0);
`endif

        idle(5);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("err_drained", eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
